ps2_key_decoder: RTL and testbench

- Receives raw PS/2 keyboard frames and decodes scan-code set 2 make/break sequences into level "key is pressed" flags.
- Flags drive the paddle/rod movement logic: key8IsPressed/key2IsPressed for team A, keyWIsPressed/keySIsPressed for team B.
- Sits between the board PS/2 pins and the movement blocks, all in the clk domain.

---
 rtl/ps2_key_decoder.sv | 127 ++++++++++++
 tb/tb_ps2_key_decoder.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 receiver that turns make/break codes into held-key flags.
module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter logic [7:0] CODE_8 = 8'h75,
  parameter logic [7:0] CODE_2 = 8'h72,
  parameter logic [7:0] CODE_W = 8'h1D,
  parameter logic [7:0] CODE_S = 8'h1B
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key8IsPressed,
  output logic       key2IsPressed,
  output logic       keyWIsPressed,
  output logic       keySIsPressed,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_error
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [1:0] clk_sync, data_sync;
  logic clk_filt;
  logic [FW-1:0] filt_cnt;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic par;
  logic [TW-1:0] tmo;
  logic break_pending, ext_pending;
  logic clk_s, data_s, fall, timeout, good;
  assign clk_s = clk_sync[1];
  assign data_s = data_sync[1];
  // the fall is the very cycle the filter accepts a low level
  assign fall = clk_filt & ~clk_s & (filt_cnt == FW'(FILTER_LEN - 1));
  assign timeout = (state != IDLE) & ~fall & (tmo == TW'(TIMEOUT_CYCLES - 1));
  assign good = data_s & (^{shift, par});
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      clk_sync <= 2'b11;
      data_sync <= 2'b11;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      if (clk_s == clk_filt) filt_cnt <= '0;
      else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s;
        filt_cnt <= '0;
      end else filt_cnt <= filt_cnt + 1'b1;
    end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state <= IDLE;
      bit_cnt <= '0;
      shift <= '0;
      par <= 1'b0;
      tmo <= '0;
      break_pending <= 1'b0;
      ext_pending <= 1'b0;
      key8IsPressed <= 1'b0;
      key2IsPressed <= 1'b0;
      keyWIsPressed <= 1'b0;
      keySIsPressed <= 1'b0;
      scan_code <= '0;
      code_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_error <= 1'b0;
      tmo <= (state == IDLE || fall || timeout) ? '0 : tmo + 1'b1;
      if (timeout) begin
        state <= IDLE;
        frame_error <= 1'b1;
        break_pending <= 1'b0;
        ext_pending <= 1'b0;
      end else if (fall) begin
        case (state)
          IDLE:
            if (!data_s) begin
              state <= DATA;
              bit_cnt <= '0;
            end else begin
              frame_error <= 1'b1;
              break_pending <= 1'b0;
              ext_pending <= 1'b0;
            end
          DATA: begin
            shift <= {data_s, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd7) state <= PARITY;
          end
          PARITY: begin
            par <= data_s;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (good) begin
              scan_code <= shift;
              code_valid <= 1'b1;
              if (shift == 8'hF0) break_pending <= 1'b1;
              else if (shift == 8'hE0) ext_pending <= 1'b1;
              else begin
                if (!ext_pending) begin
                  if (shift == CODE_8) key8IsPressed <= ~break_pending;
                  if (shift == CODE_2) key2IsPressed <= ~break_pending;
                  if (shift == CODE_W) keyWIsPressed <= ~break_pending;
                  if (shift == CODE_S) keySIsPressed <= ~break_pending;
                end
                break_pending <= 1'b0;
                ext_pending <= 1'b0;
              end
            end else begin
              frame_error <= 1'b1;
              break_pending <= 1'b0;
              ext_pending <= 1'b0;
            end
          end
        endcase
      end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed PS/2 frames with a queue-based event scoreboard.
module tb_ps2_key_decoder;
  localparam int H = 20;
  logic clk = 1'b0, resetN = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic key8IsPressed, key2IsPressed, keyWIsPressed, keySIsPressed;
  logic [7:0] scan_code;
  logic code_valid, frame_error;
  logic [3:0] flags;
  typedef struct packed {logic err; logic [7:0] code; logic [3:0] fl;} ev_t;
  ev_t q[$];
  ev_t e_mon;
  int checks = 0, errors = 0;
  logic [3:0] cur_flags = 4'b0;

  ps2_key_decoder dut (
    .clk(clk), .resetN(resetN), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key8IsPressed(key8IsPressed), .key2IsPressed(key2IsPressed),
    .keyWIsPressed(keyWIsPressed), .keySIsPressed(keySIsPressed),
    .scan_code(scan_code), .code_valid(code_valid), .frame_error(frame_error)
  );

  always #5 clk = ~clk;
  assign flags = {key8IsPressed, key2IsPressed, keyWIsPressed, keySIsPressed};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (!resetN) cur_flags = 4'b0;
    else if (code_valid || frame_error) begin
      if (q.size() == 0) chk("unexpected_event", {30'b0, code_valid, frame_error}, 32'b0);
      else begin
        e_mon = q.pop_front();
        chk("event_kind", {30'b0, code_valid, frame_error}, e_mon.err ? 32'd1 : 32'd2);
        if (!e_mon.err) chk("scan_code", {24'b0, scan_code}, {24'b0, e_mon.code});
        chk("flags_at_event", {28'b0, flags}, {28'b0, e_mon.fl});
        cur_flags = e_mon.fl;
      end
    end else chk("flags_steady", {28'b0, flags}, {28'b0, cur_flags});

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (H) @(negedge clk);
    ps2_data = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] b, input logic par_ok, input logic stop,
                       input logic err, input logic [3:0] fl);
    q.push_back('{err: err, code: b, fl: fl});
    send_bits({stop, par_ok ? ~^b : ^b, b, 1'b0}, 11);
  endtask

  task automatic good(input logic [7:0] b, input logic [3:0] fl);
    frame(b, 1'b1, 1'b1, 1'b0, fl);
  endtask

  task automatic check_cleared(input string name);
    chk({name, "_flags"}, {28'b0, flags}, 32'b0);
    chk({name, "_scan_code"}, {24'b0, scan_code}, 32'b0);
    chk({name, "_pulses"}, {30'b0, code_valid, frame_error}, 32'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 check_cleared("reset");
    resetN = 1'b1;
    repeat (10) @(negedge clk);
    good(8'h75, 4'b1000);
    good(8'hF0, 4'b1000);
    good(8'h75, 4'b0000);
    good(8'h72, 4'b0100);
    good(8'h1D, 4'b0110);
    good(8'hF0, 4'b0110);
    good(8'h72, 4'b0010);
    good(8'hE0, 4'b0010);
    good(8'h75, 4'b0010);
    good(8'h75, 4'b1010);
    good(8'hF0, 4'b1010);
    good(8'h75, 4'b0010);
    frame(8'h75, 1'b0, 1'b1, 1'b1, 4'b0010);
    good(8'hF0, 4'b0010);
    frame(8'h75, 1'b1, 1'b0, 1'b1, 4'b0010);
    good(8'h75, 4'b1010);
    good(8'h75, 4'b1010);
    q.push_back('{err: 1'b1, code: 8'h00, fl: 4'b1010});
    send_bits({2'b11, 8'h1B, 1'b0}, 5);
    repeat (10100) @(negedge clk);
    good(8'h1B, 4'b1011);
    good(8'h1C, 4'b1011);
    good(8'hF0, 4'b1011);
    q.push_back('{err: 1'b1, code: 8'h00, fl: 4'b1011});
    send_bits(11'h001, 1);
    good(8'h1B, 4'b1011);
    good(8'hF0, 4'b1011);
    good(8'h72, 4'b1011);
    for (int i = 0; i < 4; i++) begin
      ps2_data = i[0];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    #3 resetN = 1'b0;
    #1 check_cleared("midframe_reset");
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    resetN = 1'b1;
    repeat (10) @(negedge clk);
    good(8'h72, 4'b0100);
    repeat (200) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
